mem_master: RTL and testbench

Bus initiator for the processor's data memory: accepts load/store requests from the pipeline's memory stage and drives the shared chip-select / word-address / bidirectional-data / write bus of the 256 × 32 data memory. Handles the memory's registered read timing, bus turnaround, sub-word extraction with sign/zero extension, and sub-word stores by read-modify-write. Sits between the MEM pipeline stage and the data memory.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_if.sv | 27 ++
 rtl/mem_subword.sv | 37 +++
 rtl/mem_master.sv | 154 +++++++++++++++
 tb/tb_mem_master.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory bus master.
package mem_pkg;

  localparam int unsigned DataW     = 32;
  localparam int unsigned WordAddrW = 8;
  localparam int unsigned ByteAddrW = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StWr,
    StErr
  } state_e;

endpackage

// File: rtl/mem_if.sv
// Request/response handshake between the MEM pipeline stage and mem_master.
interface mem_if;
  import mem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ByteAddrW-1:0] req_addr;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [DataW-1:0]     req_wdata;
  logic                 rsp_valid;
  logic [DataW-1:0]     rsp_rdata;
  logic                 rsp_err;

  // master = pipeline side issuing requests; slave = mem_master serving them
  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_subword.sv
// Little-endian lane extraction with sign/zero extension, and store-lane merge for RMW.
module mem_subword
  import mem_pkg::*;
(
  input  logic [DataW-1:0] word,
  input  logic [1:0]       offset,
  input  size_e            size,
  input  logic             is_unsigned,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] load_data,
  output logic [DataW-1:0] store_data
);

  logic [4:0]       shamt;
  logic [DataW-1:0] shifted;
  logic [DataW-1:0] mask;

  always_comb begin
    shamt     = {offset, 3'b000};
    shifted   = word >> shamt;
    load_data = word;
    mask      = '1;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00ff << shamt;
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_ffff << shamt;
      end
      default: ;
    endcase
    store_data = (word & ~mask) | ((wdata << shamt) & mask);
  end

endmodule

// File: rtl/mem_master.sv
// Load/store bus initiator for the 256x32 data memory (registered reads, RMW sub-word stores).
// Byte/half access is compiled in only when MEM_SUBWORD_EN is defined.
module mem_master
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mem_if.slave                 pipe,
  output logic                 chipSel,
  output logic [WordAddrW-1:0] addr,
  inout  wire  [DataW-1:0]     dat,
  output logic                 write
);

  state_e               state_q, state_d;
  logic                 write_q;
  logic [WordAddrW-1:0] addr_q;
  logic [DataW-1:0]     wdata_q;
  logic [DataW-1:0]     raw_q;
  logic                 pend_q, pend_d;
  logic                 rsp_valid_q, rsp_err_q;
  logic [DataW-1:0]     rsp_rdata_q;
  logic                 accept, capture, legal, rmw_req;
  logic [DataW-1:0]     load_word, store_word;
  size_e                req_size;
  logic [1:0]           req_off;

  assign req_size = size_e'(pipe.req_size);
  assign req_off  = pipe.req_addr[1:0];

`ifdef MEM_SUBWORD_EN
  logic [1:0] offset_q;
  size_e      size_q;
  logic       unsigned_q;

  always_comb begin
    case (req_size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~req_off[0];
      SZ_WORD: legal = (req_off == 2'b00);
      default: legal = 1'b0;
    endcase
    rmw_req = pipe.req_write & (req_size != SZ_WORD);
  end

  mem_subword u_subword (
    .word        (raw_q),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .load_data   (load_word),
    .store_data  (store_word)
  );
`else
  always_comb begin
    legal   = (req_size == SZ_WORD) && (req_off == 2'b00);
    rmw_req = 1'b0;
  end

  assign load_word  = raw_q;
  assign store_word = wdata_q;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    pend_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pipe.req_valid) begin
          accept = 1'b1;
          if (!legal)                           state_d = StErr;
          else if (pipe.req_write && !rmw_req)  state_d = StWr;
          else                                  state_d = StRd0;
        end
      end
      StRd0: state_d = StRd1;
      StRd1: begin
        capture = 1'b1;
`ifdef MEM_SUBWORD_EN
        if (write_q) begin
          state_d = StWr;
        end else begin
          state_d = StIdle;
          pend_d  = 1'b1;
        end
`else
        state_d = StIdle;
        pend_d  = 1'b1;
`endif
      end
      StWr: begin
        state_d = StIdle;
        pend_d  = 1'b1;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus pins depend on registered state/fields only
  always_comb begin
    chipSel = (state_q == StRd0) || (state_q == StRd1) || (state_q == StWr);
    write   = (state_q == StWr);
    addr    = chipSel ? addr_q : '0;
  end

  assign dat = write ? store_word : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      raw_q       <= '0;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_SUBWORD_EN
      offset_q    <= '0;
      size_q      <= SZ_BYTE;
      unsigned_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        write_q <= pipe.req_write;
        addr_q  <= pipe.req_addr[ByteAddrW-1:2];
        wdata_q <= pipe.req_wdata;
`ifdef MEM_SUBWORD_EN
        offset_q   <= req_off;
        size_q     <= req_size;
        unsigned_q <= pipe.req_unsigned;
`endif
      end
      if (capture) raw_q <= dat;
      // Response lags the last bus cycle by one, so the next accept can overlap it
      rsp_valid_q <= pend_q | (state_q == StErr);
      rsp_err_q   <= (state_q == StErr);
      rsp_rdata_q <= (pend_q && !write_q) ? load_word : '0;
    end
  end

  assign pipe.req_ready = (state_q == StIdle);
  assign pipe.rsp_valid = rsp_valid_q;
  assign pipe.rsp_err   = rsp_err_q;
  assign pipe.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a registered-read 256x32 memory model on the shared bus.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chipSel;
  logic [7:0]  addr;
  logic        write;
  wire  [31:0] dat;

  mem_if bus ();

  mem_master dut (
    .clk     (clk),
    .rst     (rst),
    .pipe    (bus),
    .chipSel (chipSel),
    .addr    (addr),
    .dat     (dat),
    .write   (write)
  );

  always #5 clk = ~clk;

  // Memory model: read data registered, driven during the following cycle, released on write
  logic [31:0] mem [256];
  logic [31:0] rd_q   = '0;
  logic        rd_en_q = 1'b0;

  always @(posedge clk) begin
    if (chipSel && write) mem[addr] <= dat;
    if (chipSel && !write) begin
      rd_q    <= mem[addr];
      rd_en_q <= 1'b1;
    end else begin
      rd_en_q <= 1'b0;
    end
  end

  assign dat = (rd_en_q && !write) ? rd_q : 'z;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_op(input string tag, input logic w, input logic [9:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat,
                        output logic cs_seen, output logic [31:0] wr_dat);
    int lat;
    logic [31:0] rd;
    logic er;
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    wr_dat = '0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cs_seen = chipSel;
    if (write) wr_dat = dat;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat = i;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        check({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
        break;
      end
      if (chipSel) cs_seen = 1'b1;
      if (write) wr_dat = dat;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  logic        cs;
  logic [31:0] wdv;
  logic        saw_rsp;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    repeat (2) @(negedge clk);
    check("rst.ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst.rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("rst.chipSel", {31'b0, chipSel}, 32'd0);
    check("rst.write", {31'b0, write}, 32'd0);
    check("rst.addr", {24'b0, addr}, 32'd0);
    rst = 1'b0;

    run_op("st_word", 1'b1, 10'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2, cs, wdv);
    check("st_word.dat", wdv, 32'hDEADBEEF);
    run_op("ld_word", 1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, cs, wdv);
    check("ld_word.cs", {31'b0, cs}, 32'd1);
    run_op("ld_half_mis", 1'b0, 10'h013, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1, cs, wdv);
    check("ld_half_mis.cs", {31'b0, cs}, 32'd0);
    run_op("ld_size11", 1'b0, 10'h000, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1, cs, wdv);
    run_op("st_word_mis", 1'b1, 10'h012, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b1, 1, cs, wdv);
    check("st_word_mis.cs", {31'b0, cs}, 32'd0);
    run_op("ld_after_err", 1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3, cs, wdv);

`ifdef MEM_SUBWORD_EN
    run_op("st_pat", 1'b1, 10'h020, 2'b10, 1'b0, 32'h80FF7F01, 32'h0, 1'b0, 2, cs, wdv);
    run_op("ld_b2_s", 1'b0, 10'h022, 2'b00, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 3, cs, wdv);
    run_op("ld_b3_u", 1'b0, 10'h023, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 3, cs, wdv);
    run_op("ld_h2_s", 1'b0, 10'h022, 2'b01, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 3, cs, wdv);
    run_op("ld_b1_s", 1'b0, 10'h021, 2'b00, 1'b0, 32'h0, 32'h0000007F, 1'b0, 3, cs, wdv);
    run_op("ld_h0_u", 1'b0, 10'h020, 2'b01, 1'b1, 32'h0, 32'h00007F01, 1'b0, 3, cs, wdv);
    run_op("st_base", 1'b1, 10'h030, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 2, cs, wdv);
    run_op("st_b1", 1'b1, 10'h031, 2'b00, 1'b0, 32'h000000AA, 32'h0, 1'b0, 4, cs, wdv);
    check("st_b1.dat", wdv, 32'h1122AA44);
    run_op("ld_b1_word", 1'b0, 10'h030, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0, 3, cs, wdv);
    run_op("st_h2", 1'b1, 10'h032, 2'b01, 1'b0, 32'h0000BEEF, 32'h0, 1'b0, 4, cs, wdv);
    run_op("ld_h2_word", 1'b0, 10'h030, 2'b10, 1'b0, 32'h0, 32'hBEEFAA44, 1'b0, 3, cs, wdv);
`else
    run_op("ld_byte_off", 1'b0, 10'h010, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1, cs, wdv);
    check("ld_byte_off.cs", {31'b0, cs}, 32'd0);
    run_op("st_half_off", 1'b1, 10'h010, 2'b01, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, 1, cs, wdv);
`endif

    // Abort a write-bearing operation before its WR edge
    run_op("st_orig", 1'b1, 10'h040, 2'b10, 1'b0, 32'h55667788, 32'h0, 1'b0, 2, cs, wdv);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_addr     = 10'h041;
`ifdef MEM_SUBWORD_EN
    bus.req_size     = 2'b00;
`else
    bus.req_size     = 2'b10;
    bus.req_addr     = 10'h040;
`endif
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h000000AA;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
`ifdef MEM_SUBWORD_EN
    @(posedge clk);
    #1;
    check("abort.in_rd1", {31'b0, chipSel & ~write}, 32'd1);
`endif
    rst = 1'b1;
    #1;
    check("abort.chipSel", {31'b0, chipSel}, 32'd0);
    check("abort.write", {31'b0, write}, 32'd0);
    check("abort.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("abort.ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    saw_rsp = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("abort.no_rsp", {31'b0, saw_rsp}, 32'd0);
    run_op("ld_orig", 1'b0, 10'h040, 2'b10, 1'b0, 32'h0, 32'h55667788, 1'b0, 3, cs, wdv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
